register_bank: RTL and testbench

Parametrised multi-port integer register file for the core's decode/writeback path. It adds three things over a plain flop array: configurable width, depth and port counts, a per-entry busy scoreboard for in-flight results, and a sequenced post-reset clear with a `ready` flag. Entry 0 is hardwired to zero.

---
 rtl/register_bank.sv | 115 +++++++++++
 tb/tb_register_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: multi-port register file with a per-entry busy scoreboard and a sequenced post-reset clear.
// Define REGISTER_BANK_BYPASS_EN to forward same-cycle write data (and a cleared busy) to matching reads.
module register_bank #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned RPORTS = 2,
    parameter int unsigned WPORTS = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [RPORTS-1:0]        rden,
    input  logic [RPORTS*AW-1:0]     raddr,
    output logic [RPORTS*XLEN-1:0]   rdata,
    output logic [RPORTS-1:0]        rbusy,
    input  logic [WPORTS-1:0]        wren,
    input  logic [WPORTS*AW-1:0]     waddr,
    input  logic [WPORTS*XLEN-1:0]   wdata,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr
);

    typedef enum logic [1:0] {INIT, CLEAR, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [XLEN-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;

    logic [AW-1:0]   wa [WPORTS];
    logic [XLEN-1:0] wd [WPORTS];
    logic [AW-1:0]   ra [RPORTS];

    always_comb begin
        for (int unsigned w = 0; w < WPORTS; w++) begin
            wa[w] = waddr[w*AW +: AW];
            wd[w] = wdata[w*XLEN +: XLEN];
        end
        for (int unsigned p = 0; p < RPORTS; p++) begin
            ra[p] = raddr[p*AW +: AW];
        end
    end

    // Control, ready flag and scoreboard; issue is applied after write-clears so set wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    state <= CLEAR;
                    cnt   <= '0;
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    for (int unsigned w = 0; w < WPORTS; w++) begin
                        if (wren[w] && wa[w] != '0) begin
                            busy[wa[w]] <= 1'b0;
                        end
                    end
                    if (iss_en && iss_addr != '0) begin
                        busy[iss_addr] <= 1'b1;
                    end
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage; later write ports override earlier ones on an address collision.
    always_ff @(posedge clk) begin
        if (rst && state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (rst && state == RUN) begin
            for (int unsigned w = 0; w < WPORTS; w++) begin
                if (wren[w] && wa[w] != '0) begin
                    mem[wa[w]] <= wd[w];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned p = 0; p < RPORTS; p++) begin
            if (state == RUN && rden[p] && ra[p] != '0) begin
                rdata[p*XLEN +: XLEN] = mem[ra[p]];
                rbusy[p]              = busy[ra[p]];
`ifdef REGISTER_BANK_BYPASS_EN
                for (int unsigned w = 0; w < WPORTS; w++) begin
                    if (wren[w] && wa[w] == ra[p]) begin
                        rdata[p*XLEN +: XLEN] = wd[w];
                        rbusy[p]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: randomized traffic against a behavioural model plus directed literal checks.
module tb_register_bank;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned RPORTS = 2;
    localparam int unsigned WPORTS = 2;
    localparam int unsigned AW     = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   ready;
    logic [RPORTS-1:0]      rden;
    logic [RPORTS*AW-1:0]   raddr;
    logic [RPORTS*XLEN-1:0] rdata;
    logic [RPORTS-1:0]      rbusy;
    logic [WPORTS-1:0]      wren;
    logic [WPORTS*AW-1:0]   waddr;
    logic [WPORTS*XLEN-1:0] wdata;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    register_bank #(.XLEN(XLEN), .DEPTH(DEPTH), .RPORTS(RPORTS), .WPORTS(WPORTS)) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rden(rden), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wren(wren), .waddr(waddr), .wdata(wdata),
        .iss_en(iss_en), .iss_addr(iss_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [XLEN-1:0] m_mem [DEPTH];
    bit              m_busy [DEPTH];
    bit              m_ready = 1'b0;
    int              since_release = 0;

    initial begin
        logic [XLEN-1:0] exp_d;
        bit              exp_b;
        int unsigned     a;
        while (!done) begin
            @(negedge clk);
            #4;
            if (done) break;
            chk("ready", ready, m_ready);
            for (int unsigned p = 0; p < RPORTS; p++) begin
                a     = raddr[p*AW +: AW];
                exp_d = '0;
                exp_b = 1'b0;
                if (m_ready && rden[p] && a != 0) begin
                    exp_d = m_mem[a];
                    exp_b = m_busy[a];
`ifdef REGISTER_BANK_BYPASS_EN
                    for (int unsigned w = 0; w < WPORTS; w++) begin
                        if (wren[w] && waddr[w*AW +: AW] == a) begin
                            exp_d = wdata[w*XLEN +: XLEN];
                            exp_b = 1'b0;
                        end
                    end
`endif
                end
                chk($sformatf("rdata%0d", p), rdata[p*XLEN +: XLEN], exp_d);
                chk($sformatf("rbusy%0d", p), rbusy[p], exp_b);
            end
            // advance model to the upcoming rising edge
            if (!rst) begin
                m_ready = 1'b0;
                since_release = 0;
                for (int unsigned i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
            end else if (m_ready) begin
                for (int unsigned w = 0; w < WPORTS; w++) begin
                    a = waddr[w*AW +: AW];
                    if (wren[w] && a != 0) begin
                        m_mem[a]  = wdata[w*XLEN +: XLEN];
                        m_busy[a] = 1'b0;
                    end
                end
                if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
            end else begin
                since_release++;
                if (since_release == DEPTH + 1) begin
                    m_ready = 1'b1;
                    for (int unsigned i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        rden = '0; raddr = '0; wren = '0; waddr = '0; wdata = '0;
        iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic read2(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rden = 2'b11;
        raddr = {a1, a0};
    endtask

    function automatic logic [AW-1:0] pick();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom);
    endfunction

    // Releases reset and returns the 1-based cycle on which ready is first seen high.
    task automatic release_count(output int first);
        first = 0;
        for (int unsigned k = 1; k <= 40; k++) begin
            @(negedge clk);
            idle();
            rst = 1'b1;
            if (k <= 20) begin
                wren = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h0000_0055};
                iss_en = 1'b1; iss_addr = 5'd6;
            end
            #4;
            if (k == 1) chk("ready_low_after_reset", ready, 1'b0);
            if (ready && first == 0) first = int'(k);
            if (first != 0) break;
        end
    endtask

    task automatic all_zero();
        for (int unsigned a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            idle();
            read2(AW'(a), AW'(a));
            #4;
            chk("cleared_p0", rdata[31:0], 64'h0);
            chk("cleared_p1", rdata[63:32], 64'h0);
            chk("cleared_busy", rbusy, 64'h0);
        end
    endtask

    task automatic random_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            rden     = 2'($urandom);
            raddr    = {pick(), pick()};
            wren     = 2'($urandom);
            waddr    = {pick(), pick()};
            wdata    = {$urandom, $urandom};
            iss_en   = ($urandom_range(0, 3) == 0);
            iss_addr = pick();
        end
    endtask

    initial begin
        int first;
        rst = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #4;
        chk("reset_ready", ready, 1'b0);
        chk("reset_rdata", rdata, 64'h0);
        chk("reset_rbusy", rbusy, 64'h0);

        release_count(first);
        chk("ready_cycle", first, 64'd34);
        all_zero();

        // basic write/read and entry 0
        @(negedge clk); idle();
        wren = 2'b11; waddr = {5'd0, 5'd5}; wdata = {32'h0000_1234, 32'hDEAD_BEEF};
        @(negedge clk); idle(); read2(5'd5, 5'd5); #4;
        chk("wr5_p0", rdata[31:0], 64'hDEAD_BEEF);
        chk("wr5_p1", rdata[63:32], 64'hDEAD_BEEF);
        @(negedge clk); idle(); read2(5'd0, 5'd0); #4;
        chk("entry0", rdata, 64'h0);

        // write conflict
        @(negedge clk); idle();
        wren = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11};
        @(negedge clk); idle(); read2(5'd7, 5'd7); #4;
        chk("conflict", rdata[31:0], 64'h22);

        // scoreboard
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd9;
        @(negedge clk); idle(); read2(5'd9, 5'd9); #4;
        chk("busy_set", rbusy, 64'h3);
        @(negedge clk); idle(); wren = 2'b01; waddr = {5'd0, 5'd9}; wdata = {32'h0, 32'h99};
        @(negedge clk); idle(); read2(5'd9, 5'd9); #4;
        chk("busy_clr", rbusy, 64'h0);
        @(negedge clk); idle(); wren = 2'b10; waddr = {5'd9, 5'd0}; wdata = {32'h98, 32'h0};
        iss_en = 1'b1; iss_addr = 5'd9;
        @(negedge clk); idle(); read2(5'd9, 5'd9); #4;
        chk("busy_setwins", rbusy, 64'h3);
        chk("setwins_data", rdata[31:0], 64'h98);

        // same-cycle read of an entry being written
        @(negedge clk); idle(); iss_en = 1'b1; iss_addr = 5'd3;
        wren = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'h1};
        @(negedge clk); idle(); wren = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'h0, 32'hCAFE};
        read2(5'd3, 5'd3); #4;
`ifdef REGISTER_BANK_BYPASS_EN
        chk("bypass_data", rdata[31:0], 64'hCAFE);
        chk("bypass_busy", rbusy[0], 64'h0);
`else
        chk("nobypass_data", rdata[31:0], 64'h1);
        chk("nobypass_busy", rbusy[0], 64'h1);
`endif
        @(negedge clk); idle(); read2(5'd3, 5'd3); #4;
        chk("after_wr3", rdata[31:0], 64'hCAFE);

        random_cycles(1500);

        // mid-run reset
        @(negedge clk); idle(); rst = 1'b0;
        release_count(first);
        chk("ready_cycle_rerun", first, 64'd34);
        all_zero();

        random_cycles(400);

        @(negedge clk); idle();
        done = 1'b1;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
